dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter sharing the single-port synchronous data RAM behind `proc` between the processor load/store port (requester 0) and the switch/IO debug port (requester 1). It accepts one transaction at a time, drives the RAM, and returns read data to the owner. Arbitration is round-robin or fixed core priority. It sits between `proc`'s data bus and the data RAM in the top level.

## Interface
- `ADDR_W`, 8, RAM word-address width
- `DATA_W`, 32, data width
- `CORE_PRIO`, 0, 0 = round-robin; 1 = requester 0 always wins ties
- `clk`  in  1  clock, rising edge
- `reset`  in  1  reset, asynchronous, active-high
- `m0_req`, `m1_req`  in  1  request, held until grant
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  ADDR_W  word address
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data
- `m0_gnt`, `m1_gnt`  out  1  one-cycle pulse; request captured
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle pulse; read data valid
- `m0_rdata`, `m1_rdata`  out  DATA_W  read data; 0 when matching rvalid is low
- `ram_en`, `ram_we`  out  1  RAM enable and write enable
- `ram_addr`  out  ADDR_W  RAM address
- `ram_wdata`  out  DATA_W  RAM write data
- `ram_rdata`  in  DATA_W  RAM read data, valid the cycle after `ram_en` with `ram_we`=0

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any `mX_req`=1, capture the winner's `we/addr/wdata` and owner id, then go to ACCESS; else stay.
- ACCESS, exactly one cycle: `ram_en`=1, `ram_we`/`ram_addr`/`ram_wdata` equal the captured values, `mX_gnt`=1 for the owner only. Always go to RESP.
- RESP, exactly one cycle: for a read, owner's `mX_rvalid`=1 and `mX_rdata`=`ram_rdata`. For a write, no rvalid; the gnt pulse is the completion. RESP arbitrates like IDLE: a request goes to ACCESS, otherwise go to IDLE.
- Tie-break: register `last` holds the id of the last granted requester and is updated on every gnt. With both requesting and `CORE_PRIO`=0, the winner is the id opposite `last`. With `CORE_PRIO`=1, requester 0 wins. A single requester always wins.
- Requester rule: `mX_req` and its operands stay stable until `mX_gnt`. Requester drops `req` on the edge after gnt unless it has a new transaction. A `req` seen in RESP is a new request.
- No transaction can be preempted once it is captured.

## Timing
- Reset (asynchronous): state=IDLE and `last`=1, so requester 0 wins the first tie. All outputs are 0: gnt, rvalid, `ram_en`, `ram_we`, `ram_addr`, `ram_wdata`. `mX_rdata` is 0.
- Reset mid-transaction: the captured transaction is dropped. No gnt and no rvalid are issued afterwards, and the RAM is not written if reset is asserted before the ACCESS edge.
- Latency: req high in cycle N with arbiter idle gives gnt and RAM access in N+1, then rvalid (read) in N+2.
- Throughput: back-to-back requests give one transaction per 2 cycles (ACCESS/RESP alternating).
- `ram_*`, gnt, and rvalid are registered outputs. `mX_rdata` is `ram_rdata` gated by the owner's rvalid (combinational).
- Both gnts are never high together, and both rvalids are never high together.

## Test plan
- Reset with `m0_req`=`m1_req`=1: after release, first gnt is `m0_gnt`, then `m1_gnt`, then `m0_gnt`, …, spaced 2 cycles apart.
- Requester 1 writes 0xDEADBEEF to addr 0x1C, then requester 0 reads 0x1C: `ram_we`=1 with addr 0x1C on m1's gnt cycle; `m0_rvalid`=1 with `m0_rdata`=0xDEADBEEF 2 cycles after m0 req; `m1_rdata` stays 0.
- `CORE_PRIO`=1 with both requesting continuously for 6 transactions: all grants go to m0 and m1 is starved; after m0 drops req, m1 is granted in the next arbitration cycle.
- Single read from m0 at addr 0x05 with RAM preloaded to 0x00000028: gnt at N+1, rvalid at N+2 with 0x28, IDLE at N+3, and `ram_en` high for exactly 1 cycle.
- Reset asserted during ACCESS of an m1 read: no `m1_rvalid`, all outputs 0 immediately (asynchronous); after release the arbiter is IDLE and m0 wins the next tie.
- Write from m0: `m0_gnt` pulses and `m0_rvalid` never asserts; a read of the same address returns the written data.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter for the single-port data RAM
module dmem_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int CORE_PRIO = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state, state_nx;
   logic              last, last_nx;
   logic              owner, owner_nx;
   logic              win1;
   logic              ram_en_nx, ram_we_nx;
   logic [ADDR_W-1:0] ram_addr_nx;
   logic [DATA_W-1:0] ram_wdata_nx;
   logic              m0_gnt_nx, m1_gnt_nx;
   logic              m0_rvalid_nx, m1_rvalid_nx;

   // Requester 1 wins when alone, or on a tie in round-robin mode when 0 went last.
   assign win1 = m1_req && (!m0_req || ((CORE_PRIO == 0) && !last));

   always_comb begin
      state_nx     = state;
      last_nx      = last;
      owner_nx     = owner;
      ram_en_nx    = 1'b0;
      ram_we_nx    = 1'b0;
      ram_addr_nx  = '0;
      ram_wdata_nx = '0;
      m0_gnt_nx    = 1'b0;
      m1_gnt_nx    = 1'b0;
      m0_rvalid_nx = 1'b0;
      m1_rvalid_nx = 1'b0;
      case (state)
         IDLE, RESP: begin
            if (m0_req || m1_req) begin
               state_nx     = ACCESS;
               owner_nx     = win1;
               last_nx      = win1;
               ram_en_nx    = 1'b1;
               ram_we_nx    = win1 ? m1_we : m0_we;
               ram_addr_nx  = win1 ? m1_addr : m0_addr;
               ram_wdata_nx = win1 ? m1_wdata : m0_wdata;
               m0_gnt_nx    = !win1;
               m1_gnt_nx    = win1;
            end else begin
               state_nx = IDLE;
            end
         end
         ACCESS: begin
            // ram_we still holds the captured direction during ACCESS.
            state_nx     = RESP;
            m0_rvalid_nx = !ram_we && !owner;
            m1_rvalid_nx = !ram_we && owner;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         last      <= 1'b1;
         owner     <= 1'b0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
      end else begin
         state     <= state_nx;
         last      <= last_nx;
         owner     <= owner_nx;
         ram_en    <= ram_en_nx;
         ram_we    <= ram_we_nx;
         ram_addr  <= ram_addr_nx;
         ram_wdata <= ram_wdata_nx;
         m0_gnt    <= m0_gnt_nx;
         m1_gnt    <= m1_gnt_nx;
         m0_rvalid <= m0_rvalid_nx;
         m1_rvalid <= m1_rvalid_nx;
      end
   end

   assign m0_rdata = m0_rvalid ? ram_rdata : '0;
   assign m1_rdata = m1_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [7:0]  m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        ram_en, ram_we;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wdata, ram_rdata;

   logic        p0_req, p1_req;
   logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
   logic [31:0] p0_rdata, p1_rdata;
   logic        p_ram_en, p_ram_we;
   logic [7:0]  p_ram_addr;
   logic [31:0] p_ram_wdata;
   logic [31:0] p_ram_rdata;

   logic [31:0] mem [0:255];

   typedef struct {
      logic        kind;
      logic        id;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t sbq[$];
   exp_t me;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   en_cnt = 0;
   int   gnt_cnt = 0;
   int   k;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .CORE_PRIO(0)) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .CORE_PRIO(1)) u_prio (
      .clk(clk), .reset(reset),
      .m0_req(p0_req), .m0_we(1'b0), .m0_addr(8'h03), .m0_wdata(32'h0),
      .m0_gnt(p0_gnt), .m0_rvalid(p0_rvalid), .m0_rdata(p0_rdata),
      .m1_req(p1_req), .m1_we(1'b0), .m1_addr(8'h04), .m1_wdata(32'h0),
      .m1_gnt(p1_gnt), .m1_rvalid(p1_rvalid), .m1_rdata(p1_rdata),
      .ram_en(p_ram_en), .ram_we(p_ram_we), .ram_addr(p_ram_addr),
      .ram_wdata(p_ram_wdata), .ram_rdata(p_ram_rdata)
   );

   // Synchronous single-port RAM model.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h11111111;
      mem[2] <= 32'h22222222;
      mem[5] <= 32'h00000028;
      ram_rdata <= 32'h0;
   end

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else ram_rdata <= mem[ram_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push(input logic kind, input logic id, input logic we,
                       input logic [7:0] addr, input logic [31:0] data, input int c);
      exp_t e;
      e.kind = kind; e.id = id; e.we = we; e.addr = addr; e.data = data; e.cyc = c;
      sbq.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard whenever a gnt or rvalid pulse appears.
   always @(negedge clk) begin
      if (!reset) begin
         if (ram_en) en_cnt++;
         if (m0_gnt || m1_gnt) gnt_cnt++;
         chk("gnt_exclusive", 32'(m0_gnt & m1_gnt), 32'h0);
         chk("rvalid_exclusive", 32'(m0_rvalid & m1_rvalid), 32'h0);
         if (!m0_rvalid) chk("m0_rdata_gated", m0_rdata, 32'h0);
         if (!m1_rvalid) chk("m1_rdata_gated", m1_rdata, 32'h0);
         if (m0_gnt || m1_gnt || m0_rvalid || m1_rvalid) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pulse cycle=%0d gnt=%b%b rvalid=%b%b required=none",
                        cyc, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid);
            end else begin
               me = sbq.pop_front();
               chk("pulse_cycle", 32'(cyc), 32'(me.cyc));
               if (me.kind == 1'b0) begin
                  chk("gnt_owner", 32'({m1_gnt, m0_gnt}), me.id ? 32'h2 : 32'h1);
                  chk("gnt_ram_en", 32'(ram_en), 32'h1);
                  chk("gnt_ram_we", 32'(ram_we), 32'(me.we));
                  chk("gnt_ram_addr", 32'(ram_addr), 32'(me.addr));
                  chk("gnt_ram_wdata", ram_wdata, me.data);
               end else begin
                  chk("rvalid_owner", 32'({m1_rvalid, m0_rvalid}), me.id ? 32'h2 : 32'h1);
                  chk("rdata", me.id ? m1_rdata : m0_rdata, me.data);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      p0_req = 0; p1_req = 0; p_ram_rdata = 32'h0;
      repeat (3) tick();
      chk("reset_ram_en", 32'(ram_en), 32'h0);
      chk("reset_gnt", 32'({m1_gnt, m0_gnt}), 32'h0);
      chk("reset_ram_addr", 32'(ram_addr), 32'h0);

      // Both requesting out of reset: m0, m1, m0, m1 every 2 cycles.
      m0_req = 1; m0_addr = 8'h01; m1_req = 1; m1_addr = 8'h02;
      reset = 1'b0;
      k = cyc;
      push(0, 0, 0, 8'h01, 32'h0, k + 1);
      push(1, 0, 0, 8'h01, 32'h11111111, k + 2);
      push(0, 1, 0, 8'h02, 32'h0, k + 3);
      push(1, 1, 0, 8'h02, 32'h22222222, k + 4);
      push(0, 0, 0, 8'h01, 32'h0, k + 5);
      push(1, 0, 0, 8'h01, 32'h11111111, k + 6);
      push(0, 1, 0, 8'h02, 32'h0, k + 7);
      push(1, 1, 0, 8'h02, 32'h22222222, k + 8);
      repeat (7) tick();
      m0_req = 0; m1_req = 0;
      repeat (2) tick();

      // m1 writes DEADBEEF to 0x1C, then m0 reads it back.
      k = cyc;
      m1_req = 1; m1_we = 1; m1_addr = 8'h1C; m1_wdata = 32'hDEADBEEF;
      push(0, 1, 1, 8'h1C, 32'hDEADBEEF, k + 1);
      tick();
      m1_req = 0; m1_we = 0; m1_wdata = 0;
      tick();
      m0_req = 1; m0_we = 0; m0_addr = 8'h1C;
      push(0, 0, 0, 8'h1C, 32'h0, k + 3);
      push(1, 0, 0, 8'h1C, 32'hDEADBEEF, k + 4);
      tick();
      m0_req = 0;
      repeat (2) tick();

      // Single read from 0x05, then arbiter idle.
      k = cyc;
      m0_req = 1; m0_addr = 8'h05;
      push(0, 0, 0, 8'h05, 32'h0, k + 1);
      push(1, 0, 0, 8'h05, 32'h00000028, k + 2);
      tick();
      m0_req = 0;
      repeat (2) tick();
      chk("idle_ram_en", 32'(ram_en), 32'h0);
      chk("idle_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
      tick();

      // m0 write then read of the same address.
      k = cyc;
      m0_req = 1; m0_we = 1; m0_addr = 8'h0A; m0_wdata = 32'h12345678;
      push(0, 0, 1, 8'h0A, 32'h12345678, k + 1);
      tick();
      m0_req = 0; m0_we = 0; m0_wdata = 0;
      tick();
      m0_req = 1;
      push(0, 0, 0, 8'h0A, 32'h0, k + 3);
      push(1, 0, 0, 8'h0A, 32'h12345678, k + 4);
      tick();
      m0_req = 0;
      repeat (2) tick();

      // Reset during ACCESS of an m1 read drops the transaction.
      k = cyc;
      m1_req = 1; m1_addr = 8'h02;
      push(0, 1, 0, 8'h02, 32'h0, k + 1);
      tick();
      #5;
      reset = 1'b1;
      #1;
      chk("async_m1_gnt", 32'(m1_gnt), 32'h0);
      chk("async_ram_en", 32'(ram_en), 32'h0);
      chk("async_ram_addr", 32'(ram_addr), 32'h0);
      chk("async_m1_rvalid", 32'(m1_rvalid), 32'h0);
      m1_req = 0;
      tick();
      m0_req = 1; m0_addr = 8'h05; m1_req = 1; m1_addr = 8'h02;
      reset = 1'b0;
      k = cyc;
      push(0, 0, 0, 8'h05, 32'h0, k + 1);
      push(1, 0, 0, 8'h05, 32'h00000028, k + 2);
      push(0, 1, 0, 8'h02, 32'h0, k + 3);
      push(1, 1, 0, 8'h02, 32'h22222222, k + 4);
      tick();
      m0_req = 0;
      repeat (2) tick();
      m1_req = 0;
      repeat (3) tick();

      // Fixed priority: m0 holds the RAM for 6 transactions, then m1 gets in.
      p0_req = 1; p1_req = 1;
      for (int i = 1; i <= 11; i++) begin
         tick();
         if (i % 2 == 1) chk("prio_p0_gnt", 32'(p0_gnt), 32'h1);
         chk("prio_p1_starved", 32'(p1_gnt), 32'h0);
      end
      p0_req = 0;
      tick();
      chk("prio_p1_wait", 32'(p1_gnt), 32'h0);
      tick();
      chk("prio_p1_gnt", 32'(p1_gnt), 32'h1);
      chk("prio_p0_off", 32'(p0_gnt), 32'h0);
      p1_req = 0;
      repeat (3) tick();

      chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
      chk("ram_en_cycles", 32'(en_cnt), 32'(gnt_cnt));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
